inst_fetch_queue: RTL
=====================

# inst_fetch_queue

Instruction fetch stage that sits directly downstream of the PC-select logic. It takes the selected PC and redirect requests, and issues word reads to instruction memory over a request/grant/response handshake. Fetched {PC, instruction} pairs are buffered in a small FIFO, and the decode stage consumes them with a valid/ready handshake. A redirect (taken branch or jump) flushes the buffer and discards any in-flight response.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000: PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- redirect  in  1  load new fetch PC and flush; single-cycle pulse, may repeat.
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored (forced 0).
- imem_req  out  1  read request.
- imem_addr  out  32  word-aligned read address; equals fetch PC.
- imem_gnt  in  1  request accepted this cycle when imem_req=1.
- imem_rvalid  in  1  read data valid; exactly one per accepted request, at least 1 cycle after grant.
- imem_rdata  in  32  instruction word.
- ins_valid  out  1  ins_out/pc_out hold a valid instruction.
- ins_ready  in  1  decode accepts; transfer when ins_valid & ins_ready.
- ins_out  out  32  instruction at FIFO head.
- pc_out  out  32  PC of that instruction.

## Operation
- Fetch PC register (fpc):
  - reset → RESET_PC;
  - +4 on each accepted grant;
  - ← {redirect_pc[31:2],2'b00} on redirect, which has priority over increment.
  - Arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 → 0.
- FSM states:
  - RUN:
    - imem_req = (count < DEPTH) & ~redirect.
    - On req & gnt → WAIT.
    - If redirect coincides with a grant of a request already presented, the grant counts as accepted, fpc takes redirect_pc, and the FSM goes to DROP. imem_req is forced 0 in a redirect cycle, so this case arises only if the memory grants a request already presented.
  - WAIT:
    - imem_req = 0.
    - On rvalid: push {pc_of_request, rdata} into the FIFO and return to RUN.
    - On redirect without rvalid → DROP.
    - On redirect with rvalid: discard the data → RUN.
  - DROP:
    - imem_req = 0.
    - On rvalid: discard the data → RUN.
    - A redirect while in DROP updates fpc and stays in DROP.
- Only one request is outstanding at a time. The PC of the request is latched at grant.
- FIFO:
  - count range 0..DEPTH;
  - push from response;
  - pop on ins_valid & ins_ready;
  - simultaneous push and pop leaves count unchanged.
- Issue only when count < DEPTH, so a response always has space. No overflow is possible. Pop on empty never occurs because ins_valid = 0 when empty.
- Redirect:
  - the FIFO is flushed (count → 0) at the end of the cycle;
  - ins_valid is forced 0 in the redirect cycle, so no transfer occurs.
- Reset mid-operation: the FIFO is emptied, the FSM goes to RUN, fpc goes to RESET_PC, and a response still pending in memory is the integrator's responsibility (memory is reset together).

## Timing
- Reset values:
  - imem_req = 0 while rst is high;
  - imem_addr = RESET_PC;
  - ins_valid = 0, ins_out = 0, pc_out = 0.
- First cycle after rst deasserts: imem_req = 1, imem_addr = RESET_PC.
- imem_addr and imem_req stay stable until gnt.
- Minimum latency (no bypass): grant at cycle N, rvalid at N+1, ins_valid at N+2. The next request is issued at N+2.
- Sustained throughput: one instruction per 2 cycles with a 1-cycle memory latency.
- Redirect at cycle N:
  - imem_addr = new PC at N+1;
  - the first new instruction appears at N+3 at the earliest, when the memory has no outstanding request.

## Configuration
- IF_BYPASS_EN defined:
  - when FIFO count = 0, a response arrives, and there is no redirect, ins_valid, ins_out and pc_out are driven combinationally from imem_rdata and the latched PC in the same cycle;
  - if ins_ready = 1 in that cycle, the word is not pushed; otherwise it is pushed as normal.
  - Minimum latency becomes grant N → ins_valid at N+1.
- IF_BYPASS_EN undefined: all outputs are registered from the FIFO head, with 2-cycle minimum latency as above.

## Test plan
- Reset release, memory grants immediately with 1-cycle rvalid, ins_ready = 1 → requests at 0x0, 0x4, 0x8; pc_out/ins_out pairs appear in order, 2 cycles apart (1 apart for the first with IF_BYPASS_EN).
- ins_ready = 0 with DEPTH = 4 → exactly 4 responses buffered, then imem_req stays 0; a single-cycle ins_ready pulse pops 0x0 and exactly one new request (0x10) follows.
- Redirect to 0x0000_1003 while in WAIT → the returning word is dropped, the FIFO is emptied, the next imem_addr is 0x0000_1000, and no pc_out from the old stream appears.
- Redirect in the same cycle as rvalid in WAIT → data discarded, FSM in RUN next cycle, imem_addr = redirect target.
- redirect_pc = 0xFFFF_FFFC → fetches 0xFFFF_FFFC, then 0x0000_0000.
- rst asserted mid-WAIT with a full FIFO → ins_valid = 0 and imem_req = 0 immediately (asynchronous); after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: instruction fetch stage with a single outstanding
// request to instruction memory and a small {PC, instruction} FIFO feeding
// decode. A redirect reloads the fetch PC, flushes the FIFO and drops any
// response still in flight.
// Optional feature: define IF_BYPASS_EN to forward a response straight to
// decode when the FIFO is empty (one cycle less fetch latency).
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins_out,
  output logic [31:0] pc_out
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_DROP} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [63:0]   mem_q [DEPTH];  // entry = {pc, instruction}

  logic req_presented;  // request visible to memory if no redirect masks it
  logic accept;         // memory took the presented request this cycle
  logic resp_ok;        // response that belongs to the live stream
  logic bypass;         // response forwarded combinationally to decode
  logic push, pop, fifo_nonempty;

  // Low address bits of a redirect target are forced to zero, never read.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^redirect_pc[1:0];

  assign fifo_nonempty = (count_q != '0);
  // Requests are only issued with room left, so a response always fits.
  assign req_presented = (state_q == S_RUN) && (count_q < DEPTH_C) && !rst;
  // A grant of an already-presented request counts even in a redirect cycle.
  assign accept        = req_presented && imem_gnt;
  assign resp_ok       = (state_q == S_WAIT) && imem_rvalid && !redirect;

`ifdef IF_BYPASS_EN
  assign bypass = resp_ok && !fifo_nonempty;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word that decode takes immediately never enters the FIFO.
  assign push = resp_ok && !(bypass && ins_ready);
  assign pop  = fifo_nonempty && !redirect && ins_ready;

  // State register: FSM, fetch PC, request PC and FIFO bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_RUN;
      fpc_q    <= RESET_PC;
      req_pc_q <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      fpc_q    <= fpc_d;
      req_pc_q <= req_pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage: written on push; contents need no reset since count gates them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {req_pc_q, imem_rdata};
    end
  end

  // Next-state logic for the request FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN: begin
        if (accept) state_d = redirect ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid)   state_d = S_RUN;   // kept or discarded, either way done
        else if (redirect) state_d = S_DROP;
      end
      S_DROP: begin
        if (imem_rvalid) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  // Datapath next state: fetch PC, request PC latch, FIFO pointers and count.
  always_comb begin
    fpc_d    = fpc_q;
    req_pc_d = req_pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (accept) begin
      req_pc_d = fpc_q;
      fpc_d    = fpc_q + 32'd4;  // wraps modulo 2^32
    end
    if (redirect) begin
      fpc_d    = {redirect_pc[31:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Output logic: memory request and decode-side view of the FIFO head.
  always_comb begin
    imem_req  = req_presented && !redirect;
    imem_addr = fpc_q;
    ins_valid = (fifo_nonempty && !redirect) || bypass;
    ins_out   = 32'h0;
    pc_out    = 32'h0;
    if (fifo_nonempty) begin
      {pc_out, ins_out} = mem_q[rd_ptr_q];
    end else if (bypass) begin
      pc_out  = req_pc_q;
      ins_out = imem_rdata;
    end
  end

endmodule
